// File: rtl/xmem_stream_ctrl_pkg.sv
// Shared types and constants for the xmem stream controller.
// Holds the FSM encoding, active-low strobe levels and instruction-bundle field positions.
package xmem_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic CEN_ACTIVE = 1'b0;
  localparam logic CEN_IDLE   = 1'b1;
  localparam logic WEN_WRITE  = 1'b0;
  localparam logic WEN_READ   = 1'b1;

  // Where the xmem control fields sit inside the 36-bit core instruction bundle.
  localparam int INST_A_XMEM_LSB   = 7;
  localparam int INST_A_XMEM_MSB   = 17;
  localparam int INST_WEN_XMEM_BIT = 18;
  localparam int INST_CEN_XMEM_BIT = 19;

endpackage

// File: rtl/xmem_stream_ctrl_addr_gen.sv
// Address generator shared by the load and read paths: captures base/len on start,
// counts accesses and produces the wrapped address plus remaining/last flags.
module xmem_addr_gen
  import xmem_stream_ctrl_pkg::*;
#(
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [addr_width-1:0] i_base,
  input  logic [addr_width:0]   i_len,
  input  logic                  i_inc,
  output logic [addr_width-1:0] o_addr,
  output logic                  o_more,
  output logic                  o_last
);

  logic [addr_width-1:0] r_base;
  logic [addr_width:0]   r_cnt;
  logic [addr_width:0]   r_len;
  logic [addr_width:0]   w_cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
    end else if (i_start) begin
      r_base <= i_base;
      r_len  <= i_len;
      r_cnt  <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  // Dropping the counter MSB makes the address wrap modulo the array depth.
  assign o_addr = r_base + r_cnt[addr_width-1:0];
  assign o_more = (r_cnt < r_len);
  assign o_last = (w_cnt_inc == r_len);

endmodule

// File: rtl/xmem_stream_ctrl.sv
// Input-SRAM sequencer: streams host words into consecutive xmem addresses (load)
// and replays a programmed address range toward the corelet with Q-valid flags (read).
module xmem_stream_ctrl
  import xmem_stream_ctrl_pkg::*;
#(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_read,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   len,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [bw*row-1:0]     in_data,
  input  logic                  rd_pause,
  output logic [bw*row-1:0]     D_xmem,
  output logic [addr_width-1:0] A_xmem,
  output logic                  CEN_xmem,
  output logic                  WEN_xmem,
  output logic                  q_valid,
  output logic                  q_last,
  output logic                  busy,
  output logic                  done
);

  state_t r_state;
  state_t w_state_next;

  logic                  w_start;
  logic                  w_hs;
  logic                  w_issue;
  logic                  w_fin_exit;
  logic                  w_abort;
  logic [addr_width-1:0] w_addr;
  logic                  w_more;
  logic                  w_last;

  logic [bw*row-1:0]     r_data;
  logic [addr_width-1:0] r_addr;
  logic                  r_cen;
  logic                  r_wen;
  logic                  r_rd_last;
  logic                  r_q_valid;
  logic                  r_q_last;
  logic                  r_done;

  xmem_addr_gen #(
    .addr_width(addr_width)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_start),
    .i_base (base_addr),
    .i_len  (len),
    .i_inc  (w_hs | w_issue),
    .o_addr (w_addr),
    .o_more (w_more),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_hs         = 1'b0;
    w_issue      = 1'b0;
    w_fin_exit   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_load || start_read) begin
          w_start = 1'b1;
          if (len == '0) begin
            w_state_next = ST_FIN;
          end else if (start_load) begin
            w_state_next = ST_LOAD;
          end else begin
            w_state_next = ST_READ;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (in_valid) begin
          w_hs = 1'b1;
          if (w_last) w_state_next = ST_FIN;
        end
      end
      ST_READ: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (!rd_pause && w_more) begin
          w_issue = 1'b1;
          if (w_last) w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        // A read still on the bus needs one more cycle for its q_valid before done.
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (!(r_cen == CEN_ACTIVE && r_wen == WEN_READ)) begin
          w_fin_exit   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_abort = abort && (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cen     <= CEN_IDLE;
      r_wen     <= WEN_READ;
      r_addr    <= '0;
      r_data    <= '0;
      r_rd_last <= 1'b0;
      r_q_valid <= 1'b0;
      r_q_last  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cen     <= CEN_IDLE;
      r_wen     <= WEN_READ;
      r_rd_last <= 1'b0;
      if (w_hs) begin
        r_cen  <= CEN_ACTIVE;
        r_wen  <= WEN_WRITE;
        r_addr <= w_addr;
        r_data <= in_data;
      end else if (w_issue) begin
        r_cen     <= CEN_ACTIVE;
        r_addr    <= w_addr;
        r_rd_last <= w_last;
      end
      r_q_valid <= (r_cen == CEN_ACTIVE) && (r_wen == WEN_READ);
      r_q_last  <= r_rd_last && !w_abort;
      r_done    <= w_fin_exit;
    end
  end

  assign D_xmem   = r_data;
  assign A_xmem   = r_addr;
  assign CEN_xmem = r_cen;
  assign WEN_xmem = r_wen;
  assign q_valid  = r_q_valid;
  assign q_last   = r_q_last;
  assign done     = r_done;
  assign in_ready = (r_state == ST_LOAD);
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_xmem_stream_ctrl.sv
// Directed and randomized bench for xmem_stream_ctrl with a behavioural SRAM and
// a transaction-level model of expected writes, read issues and Q words.
`timescale 1ns/1ps
module tb_xmem_stream_ctrl;

  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int AW    = 11;
  localparam int DW    = BW * ROW;
  localparam int DEPTH = 1 << AW;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          start_load = 1'b0;
  logic          start_read = 1'b0;
  logic [AW-1:0] base_addr  = '0;
  logic [AW:0]   len        = '0;
  logic          abort      = 1'b0;
  logic          in_valid   = 1'b0;
  logic [DW-1:0] in_data    = '0;
  logic          rd_pause   = 1'b0;
  logic          in_ready, CEN_xmem, WEN_xmem, q_valid, q_last, busy, done;
  logic [DW-1:0] D_xmem;
  logic [AW-1:0] A_xmem;

  xmem_stream_ctrl #(.bw(BW), .row(ROW), .addr_width(AW)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_read(start_read),
    .base_addr(base_addr), .len(len), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .rd_pause(rd_pause), .D_xmem(D_xmem),
    .A_xmem(A_xmem), .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .q_valid(q_valid),
    .q_last(q_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural xmem: write on CEN=0/WEN=0, registered Q on CEN=0/WEN=1.
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (CEN_xmem === 1'b0) begin
      if (WEN_xmem === 1'b0) sram[A_xmem] <= D_xmem;
      else                   sram_q <= sram[A_xmem];
    end
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          last;
  } ev_t;

  ev_t wr_log[$], iss_log[$], q_log[$];
  ev_t exp_wr[$], exp_iss[$], exp_q[$];
  int  done_log[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] words[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (CEN_xmem === 1'b0 && WEN_xmem === 1'b0) wr_log.push_back('{cyc, A_xmem, D_xmem, 1'b0});
      if (CEN_xmem === 1'b0 && WEN_xmem === 1'b1) iss_log.push_back('{cyc, A_xmem, 32'd0, 1'b0});
      if (q_valid === 1'b1) q_log.push_back('{cyc, 11'd0, sram_q, q_last});
      if (done === 1'b1) done_log.push_back(cyc);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete(); iss_log.delete(); q_log.delete(); done_log.delete();
    exp_wr.delete(); exp_iss.delete(); exp_q.delete();
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic compare_phase(input string tag, input int exp_done);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      chk({tag, "_wr_addr"}, 64'(wr_log[i].a), 64'(exp_wr[i].a));
      chk({tag, "_wr_data"}, 64'(wr_log[i].d), 64'(exp_wr[i].d));
      chk({tag, "_wr_cyc"}, 64'(wr_log[i].cyc), 64'(exp_wr[i].cyc));
    end
    chk({tag, "_niss"}, 64'(iss_log.size()), 64'(exp_iss.size()));
    for (int i = 0; i < exp_iss.size() && i < iss_log.size(); i++) begin
      chk({tag, "_iss_addr"}, 64'(iss_log[i].a), 64'(exp_iss[i].a));
      chk({tag, "_iss_cyc"}, 64'(iss_log[i].cyc), 64'(exp_iss[i].cyc));
    end
    chk({tag, "_nq"}, 64'(q_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q_log.size(); i++) begin
      chk({tag, "_q_data"}, 64'(q_log[i].d), 64'(exp_q[i].d));
      chk({tag, "_q_last"}, 64'(q_log[i].last), 64'(exp_q[i].last));
      chk({tag, "_q_cyc"}, 64'(q_log[i].cyc), 64'(exp_q[i].cyc));
    end
    chk({tag, "_ndone"}, 64'(done_log.size()), 64'(exp_done));
    $display("[%0t] %s: writes=%0d reads=%0d q=%0d done=%0d", $time, tag,
             wr_log.size(), iss_log.size(), q_log.size(), done_log.size());
    clear_logs();
  endtask

  task automatic wait_done(input string tag, input int exp_c);
    int g;
    g = 0;
    @(negedge clk);
    while (done !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_done_cyc"}, 64'(cyc), 64'(exp_c));
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    chk({tag, "_ready_idle"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // mode: 0 continuous in_valid, 1 toggling 1,0,1,0, 2 random
  task automatic do_load(input string tag, input logic [AW-1:0] b, input int n, input int mode);
    int j, g, last_hs, start_c;
    logic [AW-1:0] a;
    j = 0; g = 0; last_hs = 0;
    @(posedge clk); #1;
    start_load = 1'b1; base_addr = b; len = (AW+1)'(n); start_c = cyc;
    @(posedge clk); #1;
    start_load = 1'b0; base_addr = AW'($urandom); len = (AW+1)'($urandom);
    while (j < n && g < 4 * n + 50) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 2) == 0) : 1'($urandom_range(0, 1));
      in_data  = words[j];
      @(negedge clk);
      if (in_valid && in_ready) begin
        a = b + AW'(j);
        exp_wr.push_back('{cyc + 1, a, words[j], 1'b0});
        model_mem[a] = words[j];
        last_hs = cyc;
        j++;
      end
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 64'(j), 64'(n));
    wait_done(tag, (n == 0) ? start_c + 2 : last_hs + 2);
  endtask

  // pmode: 0 never paused, 1 paused for 3 cycles from pause_at, 2 random
  task automatic do_read(input string tag, input logic [AW-1:0] b, input int n, input int pmode,
                         input int pause_at);
    int i, g, last_iss, start_c;
    logic [AW-1:0] a;
    i = 0; g = 0; last_iss = 0;
    @(posedge clk); #1;
    start_read = 1'b1; base_addr = b; len = (AW+1)'(n); start_c = cyc;
    @(posedge clk); #1;
    start_read = 1'b0; base_addr = AW'($urandom);
    while (i < n && g < 4 * n + 50) begin
      rd_pause = (pmode == 0) ? 1'b0 : (pmode == 1) ? (g >= pause_at && g < pause_at + 3)
                                                     : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!rd_pause) begin
        a = b + AW'(i);
        exp_iss.push_back('{cyc + 1, a, 32'd0, 1'b0});
        exp_q.push_back('{cyc + 2, 11'd0, model_mem[a], (i == n - 1)});
        last_iss = cyc;
        i++;
      end
      @(posedge clk); #1;
      g++;
    end
    rd_pause = 1'b0;
    wait_done(tag, (n == 0) ? start_c + 2 : last_iss + 3);
  endtask

  initial begin
    logic [AW-1:0] b;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cen", 64'(CEN_xmem), 64'd1);
    chk("rst_wen", 64'(WEN_xmem), 64'd1);
    chk("rst_addr", 64'(A_xmem), 64'd0);
    chk("rst_data", 64'(D_xmem), 64'd0);
    chk("rst_qvalid", 64'(q_valid), 64'd0);
    chk("rst_qlast", 64'(q_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    clear_logs();

    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_load("load4", 11'h010, 4, 0);
    compare_phase("load4", 1);
    do_read("read4", 11'h010, 4, 0, 0);
    compare_phase("read4", 1);

    b = AW'($urandom_range(32, 1500));
    fill_words(5);
    do_load("load_toggle", b, 5, 1);
    compare_phase("load_toggle", 1);
    do_read("read_toggle", b, 5, 0, 0);
    compare_phase("read_toggle", 1);

    fill_words(4);
    do_load("load_wrap", 11'h7FE, 4, 2);
    compare_phase("load_wrap", 1);
    do_read("read_wrap", 11'h7FE, 4, 0, 0);
    compare_phase("read_wrap", 1);

    fill_words(6);
    do_load("load6", 11'h200, 6, 0);
    compare_phase("load6", 1);
    do_read("read_pause", 11'h200, 6, 1, 2);
    compare_phase("read_pause", 1);

    do_load("load_len0", 11'h123, 0, 0);
    compare_phase("load_len0", 1);
    do_read("read_len0", 11'h123, 0, 0, 0);
    compare_phase("read_len0", 1);

    for (int k = 0; k < 4; k++) begin
      b = AW'($urandom);
      n = $urandom_range(1, 9);
      fill_words(n);
      do_load("load_rand", b, n, 2);
      compare_phase("load_rand", 1);
      do_read("read_rand", b, n, 2, 0);
      compare_phase("read_rand", 1);
    end

    b = AW'($urandom);
    fill_words(DEPTH);
    do_load("load_full", b, DEPTH, 0);
    compare_phase("load_full", 1);
    do_read("read_full", b, DEPTH, 2, 0);
    compare_phase("read_full", 1);

    // Simultaneous starts take the load; abort after two accepted words.
    b = 11'h300;
    fill_words(6);
    @(posedge clk); #1;
    start_load = 1'b1; start_read = 1'b1; base_addr = b; len = 12'd6;
    @(posedge clk); #1;
    start_load = 1'b0; start_read = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_data = words[j];
      @(negedge clk);
      chk("both_ready", 64'(in_ready), 64'd1);
      exp_wr.push_back('{cyc + 1, b + AW'(j), words[j], 1'b0});
      model_mem[b + AW'(j)] = words[j];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ld_busy", 64'(busy), 64'd0);
    chk("abort_ld_ready", 64'(in_ready), 64'd0);
    chk("abort_ld_cen", 64'(CEN_xmem), 64'd1);
    chk("abort_ld_wen", 64'(WEN_xmem), 64'd1);
    compare_phase("abort_load", 0);

    // Abort while the final read is on the bus: its Q still arrives, q_last does not.
    @(posedge clk); #1;
    start_read = 1'b1; base_addr = 11'h010; len = 12'd2;
    @(posedge clk); #1;
    start_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_iss.push_back('{cyc + 1, 11'h010 + AW'(i), 32'd0, 1'b0});
      exp_q.push_back('{cyc + 2, 11'd0, model_mem[11'h010 + AW'(i)], 1'b0});
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_rd_busy", 64'(busy), 64'd0);
    chk("abort_rd_qvalid", 64'(q_valid), 64'd1);
    compare_phase("abort_read", 0);

    // Reset in the middle of a read clears outputs without waiting for a clock edge.
    @(posedge clk); #1;
    start_read = 1'b1; base_addr = 11'h010; len = 12'd8;
    @(posedge clk); #1;
    start_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_cen", 64'(CEN_xmem), 64'd0);
    chk("pre_rst_qvalid", 64'(q_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cen", 64'(CEN_xmem), 64'd1);
    chk("mid_rst_wen", 64'(WEN_xmem), 64'd1);
    chk("mid_rst_qvalid", 64'(q_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(A_xmem), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_log.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_ndone", 64'(done_log.size()), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
